// File: rtl/param_ring_counter_if.sv
// Control and status bundle for param_ring_counter.
// The master drives the controls and observes the counter state.
interface param_ring_counter_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2 * WIDTH);

    logic             Enable;
    logic             Mode;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] Load_value;
    logic [WIDTH-1:0] Count_out;
    logic [PW-1:0]    Position;
    logic             Wrap;
    logic             Illegal;

    modport master (
        output Enable, Mode, Dir, Load, Load_value,
        input  Count_out, Position, Wrap, Illegal
    );

    modport slave (
        input  Enable, Mode, Dir, Load, Load_value,
        output Count_out, Position, Wrap, Illegal
    );
endinterface

// File: rtl/param_ring_counter.sv
// Ring (one-hot) / Johnson counter with selectable direction, parallel load,
// self-correction of illegal states, wrap and illegal-state pulses.
module param_ring_counter #(
    parameter int WIDTH = 4
) (
    input logic                 Clock,
    input logic                 Reset,
    param_ring_counter_if.slave bus
);
    localparam int PW = $clog2(2 * WIDTH);

    logic             mode_q;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             illegal_q;
    logic [WIDTH-1:0] shifted;
    logic [PW-1:0]    position;
    int unsigned      johnson_ones;

    function automatic int unsigned ones(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    // Johnson states are legal with at most one adjacent-bit transition (non-circular).
    function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
        if (m) begin
            return ones({1'b0, v[WIDTH-2:0] ^ v[WIDTH-1:1]}) <= 1;
        end
        return ones(v) == 1;
    endfunction

    always_comb begin
        shifted = count_q;
        case ({mode_q, bus.Dir})
            2'b00:   shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            2'b01:   shifted = {count_q[0], count_q[WIDTH-1:1]};
            2'b10:   shifted = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            default: shifted = {~count_q[0], count_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        position     = '0;
        johnson_ones = ones(count_q);
        if (mode_q) begin
            if (count_q == '0) begin
                position = '0;
            end else if (count_q[0]) begin
                position = PW'(johnson_ones);
            end else begin
                position = PW'(2 * WIDTH - johnson_ones);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (count_q[i]) begin
                    position = PW'(i);
                end
            end
        end
    end

    // Priority: reset, mode change, load, illegal correction, shift, hold.
    always_ff @(posedge Clock) begin
        wrap_q    <= 1'b0;
        illegal_q <= 1'b0;
        if (Reset) begin
            mode_q  <= bus.Mode;
            count_q <= seed_of(bus.Mode);
        end else if (bus.Mode != mode_q) begin
            mode_q  <= bus.Mode;
            count_q <= seed_of(bus.Mode);
        end else if (bus.Load) begin
            if (is_legal(mode_q, bus.Load_value)) begin
                count_q <= bus.Load_value;
            end else begin
                count_q   <= seed_of(mode_q);
                illegal_q <= 1'b1;
            end
        end else if (!is_legal(mode_q, count_q)) begin
            count_q   <= seed_of(mode_q);
            illegal_q <= 1'b1;
        end else if (bus.Enable) begin
            count_q <= shifted;
            wrap_q  <= (shifted == seed_of(mode_q));
        end
    end

    assign bus.Count_out = count_q;
    assign bus.Position  = position;
    assign bus.Wrap      = wrap_q;
    assign bus.Illegal   = illegal_q;
endmodule

// File: tb/tb_param_ring_counter.sv
// Randomized and directed bench for param_ring_counter; the reference model
// tracks the mode and a step index and derives the expected pattern from it.
module tb_param_ring_counter;
    localparam int WIDTH = 4;
    localparam int PW    = $clog2(2 * WIDTH);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    param_ring_counter_if #(.WIDTH(WIDTH)) bus ();

    param_ring_counter #(.WIDTH(WIDTH)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int assert_count = 0;
    int fail_count   = 0;

    bit m_mode;
    int m_k;
    bit m_wrap;
    bit m_ill;

    function automatic int period_of(bit mode);
        return mode ? 2 * WIDTH : WIDTH;
    endfunction

    // Pattern at step k: one-hot bit k for ring, k filling ones then draining for Johnson.
    function automatic logic [WIDTH-1:0] step_value(bit mode, int k);
        if (!mode) begin
            return WIDTH'(1 << k);
        end
        if (k <= WIDTH) begin
            return WIDTH'((1 << k) - 1);
        end
        return WIDTH'(((1 << WIDTH) - 1) & ~((1 << (k - WIDTH)) - 1));
    endfunction

    function automatic int find_step(bit mode, logic [WIDTH-1:0] v);
        for (int k = 0; k < period_of(mode); k++) begin
            if (step_value(mode, k) == v) begin
                return k;
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, m, en, d, ld, input logic [WIDTH-1:0] lv);
        int idx;
        m_wrap = 1'b0;
        m_ill  = 1'b0;
        if (r || (m != m_mode)) begin
            m_mode = m;
            m_k    = 0;
        end else if (ld) begin
            idx = find_step(m_mode, lv);
            if (idx < 0) begin
                m_k   = 0;
                m_ill = 1'b1;
            end else begin
                m_k = idx;
            end
        end else if (en) begin
            if (d) m_k = (m_k + period_of(m_mode) - 1) % period_of(m_mode);
            else   m_k = (m_k + 1) % period_of(m_mode);
            m_wrap = (m_k == 0);
        end
    endtask

    task automatic applyStimulus(input bit r, m, en, d, ld, input logic [WIDTH-1:0] lv);
        rst            = r;
        bus.Mode       = m;
        bus.Enable     = en;
        bus.Dir        = d;
        bus.Load       = ld;
        bus.Load_value = lv;
        @(posedge clk);
        #1;
        modelStep(r, m, en, d, ld, lv);
        checkOutput("count",    32'(bus.Count_out), 32'(step_value(m_mode, m_k)));
        checkOutput("position", 32'(bus.Position),  32'(m_k));
        checkOutput("wrap",     32'(bus.Wrap),      32'(m_wrap));
        checkOutput("illegal",  32'(bus.Illegal),   32'(m_ill));
    endtask

    logic [WIDTH-1:0] ring_seq [5]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [WIDTH-1:0] johnson_seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                          4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        bit drv_mode;
        bit r, en, d, ld;
        logic [WIDTH-1:0] lv;

        // Ring walk toward MSB from reset
        applyStimulus(1, 0, 0, 0, 0, '0);
        checkOutput("ring_reset", 32'(bus.Count_out), 32'h1);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 0, '0);
            checkOutput("ring_seq", 32'(bus.Count_out), 32'(ring_seq[i]));
        end
        checkOutput("ring_wrap_end", 32'(bus.Wrap), 32'h1);

        // Johnson walk toward MSB from reset
        applyStimulus(1, 1, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 1, 0, 0, '0);
            checkOutput("johnson_seq", 32'(bus.Count_out), 32'(johnson_seq[i]));
        end
        checkOutput("johnson_wrap_end", 32'(bus.Wrap), 32'h1);

        // Ring at 0100 shifting toward LSB
        applyStimulus(1, 0, 0, 0, 0, '0);
        applyStimulus(0, 0, 1, 0, 0, '0);
        applyStimulus(0, 0, 1, 0, 0, '0);
        applyStimulus(0, 0, 1, 1, 0, '0);
        applyStimulus(0, 0, 1, 1, 0, '0);
        checkOutput("ring_dn_wrap", 32'(bus.Wrap), 32'h1);
        applyStimulus(0, 0, 1, 1, 0, '0);
        checkOutput("ring_dn_1000", 32'(bus.Count_out), 32'h8);

        // Illegal and legal loads in ring mode
        applyStimulus(0, 0, 0, 0, 1, 4'b0110);
        checkOutput("bad_load_ill", 32'(bus.Illegal), 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 4'b1000);
        checkOutput("good_load", 32'(bus.Count_out), 32'h8);

        // Mode change beats load and enable
        applyStimulus(1, 1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, '0);
        applyStimulus(0, 0, 1, 0, 1, 4'b0100);
        checkOutput("mode_chg_seed", 32'(bus.Count_out), 32'h1);

        // Reset overrides load/enable, then hold
        applyStimulus(1, 0, 1, 0, 1, 4'b0100);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 4'b0010);
        checkOutput("hold_count", 32'(bus.Count_out), 32'h1);

        // Random traffic
        drv_mode = 1'b0;
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) drv_mode = ~drv_mode;
            en = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) lv = step_value(drv_mode, $urandom_range(0, period_of(drv_mode) - 1));
            else                          lv = WIDTH'($urandom);
            applyStimulus(r, drv_mode, en, d, ld, lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/param_ring_counter.md
PARAM_RING_COUNTER -- requirements
Module: param_ring_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 SHALL provide port Clock  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port Enable  input  1  advance one step per clock when high.
REQ-005 SHALL provide port Mode  input  1  0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-006 SHALL provide port Dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
REQ-007 SHALL provide port Load  input  1  synchronous parallel load request.
REQ-008 SHALL provide port Load_value  input  WIDTH  value to load.
REQ-009 SHALL provide port Count_out  output  WIDTH  registered counter state.
REQ-010 SHALL provide port Position  output  $clog2(2*WIDTH)  step index of Count_out.
REQ-011 SHALL provide port Wrap  output  1  registered one-cycle pulse on return to seed.
REQ-012 SHALL provide port Illegal  output  1  registered one-cycle pulse on correction.

Function
REQ-013 SHALL define the seed as {0...0,1} in ring mode and all-zeros in Johnson mode.
REQ-014 SHALL treat a state as legal:
- Ring mode: exactly one bit set.
- Johnson mode: at most one adjacent-bit transition, non-circular.
REQ-015 SHALL register Mode internally as mode_q.
REQ-016 SHALL apply per-clock priority: Reset > mode change (Mode != mode_q) > Load > illegal-state correction > Enable shift > hold.
REQ-017 SHALL, on a mode change, set Count_out to the seed of the new Mode, update mode_q, Wrap=0, Illegal=0.
REQ-018 SHALL, on Load, take Load_value if it is legal for mode_q; otherwise load the seed and pulse Illegal.
REQ-019 SHALL, with no higher-priority event and an illegal Count_out, load the seed and pulse Illegal, independent of Enable.
REQ-020 SHALL shift as follows (q = Count_out):
- Ring, Dir=0: {q[W-2:0], q[W-1]}.
- Ring, Dir=1: {q[0], q[W-1:1]}.
- Johnson, Dir=0: {q[W-2:0], ~q[W-1]}.
- Johnson, Dir=1: {~q[0], q[W-1:1]}.
REQ-021 SHALL hold Count_out when Enable=0 and no higher-priority event occurs.
REQ-022 SHALL, on the shift cycle whose result equals the seed, assert Wrap for exactly that cycle; Wrap=0 otherwise, including after loads of the seed.
REQ-023 SHALL drive Position combinationally from Count_out:
- Ring: index of the set bit.
- Johnson: 0 if q==0; popcount(q) if q[0]=1; otherwise 2*WIDTH - popcount(q).
REQ-024 SHALL leave Position don't-care while Count_out is illegal.
REQ-025 SHALL accept Dir changes on any cycle, taking effect on the next shift without re-seeding.
REQ-026 SHALL produce a ring period of WIDTH enabled cycles and a Johnson period of 2*WIDTH enabled cycles.

Reset
REQ-027 SHALL, while Reset=1 at a rising edge, set mode_q=Mode, Count_out=seed(Mode), Wrap=0, Illegal=0, overriding Load and Enable.
REQ-028 SHALL resume counting on the first edge after Reset deasserts; reset mid-sequence discards prior state.

Verification (WIDTH=4)
REQ-029 SHALL cover: Reset with Mode=0, then Enable=1, Dir=0 for 4 cycles -> 0001, 0010, 0100, 1000, 0001; Wrap high only on the final 0001; Position 0,1,2,3,0.
REQ-030 SHALL cover: Reset with Mode=1, then Enable=1, Dir=0 for 8 cycles -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; Position 1..7 then 0; Wrap high on 0000.
REQ-031 SHALL cover: Mode=0 at 0100, Dir=1 for 3 cycles -> 0010, 0001 (Wrap=1), 1000.
REQ-032 SHALL cover: Mode=0, Load=1 with Load_value=0110 -> Count_out=0001, Illegal=1 for one cycle; Load=1 with 1000 -> Count_out=1000, Illegal=0.
REQ-033 SHALL cover: Johnson at 0111, Mode switched to 0 with Load=1 and Enable=1 in the same cycle -> Count_out=0001, Wrap=0, Illegal=0.
REQ-034 SHALL cover: Reset=1 with Load=1 and Enable=1 in the same cycle -> seed loaded; Enable=0 for 5 cycles -> Count_out unchanged, no Wrap.
